// File: rtl/acc_msg_sched_gen.sv
// SHA-2 message-schedule generator: loads a 16-word block and streams W0..W(ROUNDS-1)
// over a valid/ready handshake, using a sliding 16-word window.
module acc_msg_sched_gen #(
   parameter int WORD_W = 32,
   parameter int ROUNDS = 64,
   parameter int IDX_W  = $clog2(ROUNDS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   abort,
   input  logic [16*WORD_W-1:0]   block_in,
   input  logic                   w_ready,
   output logic                   w_valid,
   output logic [WORD_W-1:0]      w_out,
   output logic [IDX_W-1:0]       w_idx,
   output logic                   busy,
   output logic                   done
);

   if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_word_w
      $error("acc_msg_sched_gen: WORD_W must be 32 or 64");
   end
   if (ROUNDS < 16 || ROUNDS > 80) begin : g_bad_rounds
      $error("acc_msg_sched_gen: ROUNDS must be in 16..80");
   end

   localparam bit          IS64  = (WORD_W == 64);
   localparam int unsigned S0_RA = IS64 ? 1  : 7;
   localparam int unsigned S0_RB = IS64 ? 8  : 18;
   localparam int unsigned S0_SH = IS64 ? 7  : 3;
   localparam int unsigned S1_RA = IS64 ? 19 : 17;
   localparam int unsigned S1_RB = IS64 ? 61 : 19;
   localparam int unsigned S1_SH = IS64 ? 6  : 10;

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state_q, state_d;
   logic [WORD_W-1:0] win_q [16];
   logic [WORD_W-1:0] win_d [16];
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              done_q, done_d;
   logic [WORD_W-1:0] sig0, sig1, new_word;
   logic              last;

   function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                              input int unsigned n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

   always_comb begin
      sig0     = rotr(win_q[1], S0_RA) ^ rotr(win_q[1], S0_RB) ^ (win_q[1] >> S0_SH);
      sig1     = rotr(win_q[14], S1_RA) ^ rotr(win_q[14], S1_RB) ^ (win_q[14] >> S1_SH);
      new_word = sig1 + win_q[9] + sig0 + win_q[0];
   end

   assign last = (idx_q == IDX_W'(ROUNDS - 1));

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               for (int unsigned k = 0; k < 16; k++) begin
                  win_d[k] = block_in[(16-k)*WORD_W-1 -: WORD_W];
               end
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // abort outranks any beat, including the final one
            if (abort) begin
               state_d = IDLE;
               idx_d   = '0;
            end else if (w_ready) begin
               for (int unsigned k = 0; k < 15; k++) begin
                  win_d[k] = win_q[k+1];
               end
               win_d[15] = new_word;
               idx_d     = idx_q + IDX_W'(1);
               if (last) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         done_q  <= 1'b0;
         for (int unsigned k = 0; k < 16; k++) begin
            win_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         win_q   <= win_d;
      end
   end

   assign w_valid = (state_q == RUN);
   assign busy    = (state_q == RUN);
   assign w_out   = win_q[0];
   assign w_idx   = idx_q;
   assign done    = done_q;

endmodule

// File: doc/acc_msg_sched_gen.md
Name: acc_msg_sched_gen

Overview:
- Parametrised SHA-2 message-schedule generator for the accelerator's hashing workers; serves SHA-256 (32-bit word, 64 rounds) or SHA-512 (64-bit word, 80 rounds) from one RTL source.
- Accepts a 16-word block on a start handshake and streams W0..W(ROUNDS-1) to the compression round unit, one word per accepted beat.
- Adds a valid/ready output handshake with backpressure, a round index, a done pulse and abort.

Parameters:
- WORD_W, 32, word width; only 32 (SHA-256 sigmas) or 64 (SHA-512 sigmas) are legal; any other value is an elaboration error.
- ROUNDS, 64, number of schedule words emitted; legal range 16..80.
- IDX_W, $clog2(ROUNDS), width of round index.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  load block_in and begin a schedule; accepted only when busy=0.
- abort  in  1  cancel the current schedule.
- block_in  in  16*WORD_W  message block; W0 = block_in[16*WORD_W-1 -: WORD_W] (big-endian word order), W15 = LSB word.
- w_ready  in  1  consumer accepts w_out this cycle.
- w_valid  out  1  w_out/w_idx hold a valid schedule word.
- w_out  out  WORD_W  current schedule word W(w_idx).
- w_idx  out  IDX_W  round index of w_out.
- busy  out  1  high while a schedule is in progress.
- done  out  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; 16-entry window cleared to 0; w_valid=0, w_out=0, w_idx=0, busy=0, done=0. Reset mid-schedule discards everything; no done.
- Window win[0..15] holds W(t)..W(t+15); w_out = win[0], w_idx = t.
- Next word is combinational: new = s1(win[14]) + win[9] + s0(win[1]) + win[0], computed modulo 2^WORD_W.
- WORD_W=32: s0 = ROTR7^ROTR18^SHR3; s1 = ROTR17^ROTR19^SHR10.
- WORD_W=64: s0 = ROTR1^ROTR8^SHR7; s1 = ROTR19^ROTR61^SHR6.
- ROTR is a true rotate and SHR a logical shift.
- States: IDLE, RUN.
- IDLE: start=1 -> load win[k] = word k of block_in, w_idx=0, go to RUN. w_valid=1 and busy=1 from the next cycle, so W0 is visible one cycle after start.
- RUN: w_valid=1. On a beat (w_valid & w_ready): win shifts down by one, win[15] <= new, w_idx++. With w_ready=0, window, w_out and w_idx hold; no data changes under backpressure.
- Last beat (w_idx==ROUNDS-1 and w_ready=1) -> IDLE. On the next cycle: done=1 for exactly one cycle, w_valid=0, busy=0.
- start is ignored while busy=1.
- start in the same cycle as done is accepted, giving back-to-back blocks with one idle cycle between W(ROUNDS-1) and the next W0.
- abort=1 in RUN -> IDLE next cycle. w_valid=0, busy=0, done stays 0; the window content is don't-care.
- abort has priority over a simultaneous beat, including the last beat. abort in IDLE has no effect. abort and start together in IDLE: abort wins and start is dropped.
- Internal next-word computation beyond ROUNDS is harmless and never observable.
- done, w_valid and busy are registered outputs; no combinational path from inputs to outputs.

Test Plan:
- WORD_W=32, "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 -> W0 appears 1 cycle after start; W16=0x61626380, W17=0x000F0000; 64 beats, then done pulses once and busy falls.
- WORD_W=64, ROUNDS=80, "abc" block (W0=0x6162638000000000, W15=0x18) -> W16=0x6162638000000000, W17=0x00030000000000C0; exactly 80 beats with w_idx 0..79, then done.
- Random w_ready toggling on the SHA-256 "abc" block -> emitted sequence identical to the w_ready=1 run; w_out/w_idx stable whenever w_ready=0.
- abort asserted at w_idx=20 while w_ready=1 -> w_valid=0 next cycle, no done; a following start yields a fresh W0 and w_idx=0.
- start held high continuously over two blocks -> second start accepted in the done cycle; start pulses during RUN ignored; second block streams correctly.
- rst_n low at w_idx=30 -> all outputs 0 immediately (asynchronous); after release, the block stays idle until the next start.
